// File: rtl/nes_button_events.sv
// nes_button_events
//   Turns the per-frame parallel button levels from the NES controller reader
//   into debounced held levels, one-cycle press pulses, D-pad auto-repeat and
//   a small first-word-fall-through event FIFO for downstream game/menu logic.
//   Buttons are sampled once per frame, on the rising edge of latch.
//
// Ports
//   clk_900KHz     in   system clock, all logic on the rising edge
//   reset          in   synchronous, active-high reset
//   latch          in   controller latch strobe from the reader
//   btn_raw[7:0]   in   button levels: a, b, select, start, up, down, left, right
//   held[7:0]      out  debounced pressed state, active-high
//   press[7:0]     out  one-cycle pulse when a held bit rises
//   evt_valid      out  event FIFO non-empty
//   evt_code[4:0]  out  {kind[1:0], idx[2:0]}; kind 00 press, 01 release, 10 repeat
//   evt_ready      in   consumer accepts the head event
//   evt_overflow   out  sticky: an event was dropped or replaced
//   clear_overflow in   clears evt_overflow
module nes_button_events #(
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 3,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk_900KHz,
  input  logic       reset,
  input  logic       latch,
  input  logic [7:0] btn_raw,
  output logic [7:0] held,
  output logic [7:0] press,
  output logic       evt_valid,
  output logic [4:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow,
  input  logic       clear_overflow
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DB_LAST    = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [7:0]  RPT_DELAY  = 8'(REPEAT_DELAY);
  localparam logic [7:0]  RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [AW:0] FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

  logic       latch_q, tick;
  logic [7:0] norm, toggle;
  logic [3:0] cnt [8];
  logic [3:0] cnt_nxt [8];
  logic [7:0] rpt [4];
  logic [7:0] rpt_nxt [4];
  logic [3:0] rpt_evt;

  logic [7:0] pend_p, pend_r, pend_t, pend_any;
  logic [7:0] srv_p, srv_r, srv_t;
  logic [7:0] keep_p, keep_r, keep_t;
  logic [7:0] ev_p, ev_r, ev_t, ev_any, replace;
  logic [7:0] pend_p_nxt, pend_r_nxt, pend_t_nxt;
  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [1:0] sel_kind;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, pop, push, drop;

  assign tick = latch & ~latch_q;
  assign norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Debounce and D-pad repeat counters
  always_comb begin
    toggle  = '0;
    rpt_evt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (norm[i] == held[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == DB_LAST) begin
          toggle[i]  = 1'b1;
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      rpt_nxt[j] = rpt[j];
      if (!held[j+4] || toggle[j+4]) begin
        rpt_nxt[j] = '0;
      end else if (tick) begin
        // Reloading DELAY-RATE rather than zero gives the steady repeat period
        if (rpt[j] + 8'd1 == RPT_DELAY) begin
          rpt_evt[j] = 1'b1;
          rpt_nxt[j] = RPT_RELOAD;
        end else begin
          rpt_nxt[j] = rpt[j] + 8'd1;
        end
      end
    end
  end

  // Serializer: lowest pending index first; release, press, repeat within an index
  always_comb begin
    pend_any  = pend_p | pend_r | pend_t;
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_kind  = '0;
    srv_p     = '0;
    srv_r     = '0;
    srv_t     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (pend_any[7-k]) begin
        sel_valid = 1'b1;
        sel_idx   = 3'(7 - k);
      end
    end
    if (sel_valid) begin
      if (pend_r[sel_idx]) begin
        sel_kind         = 2'b01;
        srv_r[sel_idx]   = 1'b1;
      end else if (pend_p[sel_idx]) begin
        sel_kind         = 2'b00;
        srv_p[sel_idx]   = 1'b1;
      end else begin
        sel_kind         = 2'b10;
        srv_t[sel_idx]   = 1'b1;
      end
    end
  end

  // New frame events replace anything still pending for the same button
  always_comb begin
    keep_p     = pend_p & ~srv_p;
    keep_r     = pend_r & ~srv_r;
    keep_t     = pend_t & ~srv_t;
    ev_p       = toggle & ~held;
    ev_r       = toggle & held;
    ev_t       = {rpt_evt, 4'b0000};
    ev_any     = ev_p | ev_r | ev_t;
    replace    = ev_any & (keep_p | keep_r | keep_t);
    pend_p_nxt = (keep_p & ~ev_any) | ev_p;
    pend_r_nxt = (keep_r & ~ev_any) | ev_r;
    pend_t_nxt = (keep_t & ~ev_any) | ev_t;
  end

  assign evt_valid = (count != '0) && !reset;
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;
  assign fifo_full = (count == FIFO_FULL);
  assign pop       = evt_valid & evt_ready;
  assign push      = sel_valid & (~fifo_full | pop);
  assign drop      = sel_valid & fifo_full & ~pop;

  always_ff @(posedge clk_900KHz) begin
    if (reset) begin
      latch_q      <= 1'b0;
      held         <= '0;
      press        <= '0;
      pend_p       <= '0;
      pend_r       <= '0;
      pend_t       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evt_overflow <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
      for (int unsigned j = 0; j < 4; j++) rpt[j] <= '0;
    end else begin
      latch_q <= latch;
      held    <= held ^ toggle;
      press   <= toggle & ~held;
      cnt     <= cnt_nxt;
      rpt     <= rpt_nxt;
      pend_p  <= pend_p_nxt;
      pend_r  <= pend_r_nxt;
      pend_t  <= pend_t_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop || (replace != '0)) evt_overflow <= 1'b1;
      else if (clear_overflow)     evt_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_900KHz) begin
    if (push) mem[wr_ptr] <= {sel_kind, sel_idx};
  end

endmodule

// File: doc/nes_button_events.md
Name: nes_button_events

Overview:
- Consumes the eight parallel button levels from the NES controller serial reader, plus its latch strobe.
- Produces debounced held levels, one-cycle press pulses, and auto-repeat for the D-pad.
- Produces a small event FIFO with valid/ready handshake for the game/menu logic downstream.
- Samples once per controller frame, on the rising edge of the latch strobe.

Parameters:
- ACTIVE_LOW, 1: button inputs are 0 when pressed (NES native); 0 = active-high.
- DEBOUNCE_FRAMES, 2: consecutive differing frames required to change a held bit (1..15; 1 = immediate).
- REPEAT_DELAY, 8: frames a D-pad button must stay held before the first repeat event (1..255).
- REPEAT_RATE, 3: frames between subsequent repeat events (1..255).
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).

Ports:
- clk_900KHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- latch  in  1  controller latch strobe from the reader, synchronous to clk_900KHz.
- btn_raw  in  8  button levels; bit order 0..7 = a, b, select, start, up, down, left, right.
- held  out  8  debounced pressed state, active-high, same bit order.
- press  out  8  one-cycle pulse per bit when its held bit rises.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  5  {kind[1:0], idx[2:0]}; kind 00 = press, 01 = release, 10 = repeat.
- evt_ready  in  1  consumer accepts the head event.
- evt_overflow  out  1  sticky: an event was dropped.
- clear_overflow  in  1  clears evt_overflow.

Behaviour:
- Reset forces all of the following to zero: latch_q, debounce counters, repeat counters, pending masks, FIFO pointers/count, held, press, evt_overflow. evt_valid = 0 and evt_code = 0 in reset. Reset mid-frame or mid-serialization discards all pending and queued events.
- Frame tick: latch_q registers latch. tick = latch & ~latch_q. Cycle T is the cycle in which tick = 1.
- At T: norm = ACTIVE_LOW ? ~btn_raw : btn_raw. For each bit i:
  - If norm[i] == held[i]: cnt[i] ← 0.
  - Else if cnt[i] + 1 == DEBOUNCE_FRAMES: held[i] toggles, cnt[i] ← 0, and a press or release event is flagged.
  - Else: cnt[i] increments.
- held and press become visible at T+1. press is high for exactly one cycle. No press pulse occurs on release or repeat.
- Auto-repeat, bits 4..7 only:
  - rpt[i] clears whenever held[i] = 0 or held[i] changes this tick.
  - On each tick with held[i] stable at 1, rpt[i] increments.
  - When rpt[i] reaches REPEAT_DELAY, flag a repeat event and set rpt[i] ← REPEAT_DELAY − REPEAT_RATE. This yields period REPEAT_RATE thereafter.
  - Buttons 0..3 never repeat.
- Pending masks pend_p, pend_r, pend_t (8 bits each) take the events flagged at T via OR at end of T.
  - If a bit is already set in any mask for the same button at a new tick, the new event replaces it and evt_overflow ← 1.
- Serializer, from T+1 on:
  - Each cycle, select the lowest index i with any pending bit. Priority within an index: release, press, repeat.
  - Push that event into the FIFO if it has space or a pop occurs this cycle, then clear that pending bit.
  - If the FIFO is full with no pop, drop the event, clear the bit, and set evt_overflow ← 1. The serializer never stalls.
  - Worst case of 8 events drains in 8 cycles, far shorter than a frame.
- FIFO: first-word-fall-through. evt_code shows the head entry whenever evt_valid = 1; it is 0 when empty.
  - A pop occurs when evt_valid & evt_ready.
  - A push into an empty FIFO gives evt_valid = 1 in the next cycle.
  - Simultaneous push and pop when full: both succeed, count unchanged.
  - Pop with evt_valid = 0 is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- evt_overflow sets on any drop or replacement and clears on clear_overflow. Set wins over clear in the same cycle.
- Latency: button change stable for DEBOUNCE_FRAMES ticks → held/press at the last tick T+1 → first event evt_valid at T+2.

Test Plan:
- Reset, then btn_raw = 8'hFF (ACTIVE_LOW) for 5 ticks → held = 0, press never high, evt_valid = 0, evt_overflow = 0.
- btn_raw = 8'hFE held for 2 ticks → held = 8'h01 after the 2nd tick. press[0] high for 1 cycle. Single event evt_code = 5'b00_000. The first tick alone produces no change.
- One-frame glitch on bit 3 (low for 1 tick, then high) → held[3] stays 0 and no events. Set DEBOUNCE_FRAMES = 1 → the same glitch yields a press then a release (5'b00_011, 5'b01_011).
- Hold up (bit 4) for 20 ticks with defaults, evt_ready = 1 → press at tick 2. Repeats (5'b10_100) at ticks 10, 13, 16, 19. Releasing yields 5'b01_100 and no further repeats.
- All 8 buttons pressed in the same frame, evt_ready = 0, FIFO_DEPTH = 4 → evt_valid at T+2. Idx 0..3 are queued, idx 4..7 dropped, evt_overflow = 1. Then evt_ready = 1 pops codes 0,1,2,3 in order, one per cycle. clear_overflow → 0.
- Assert reset while 3 events are queued and 2 are pending → next cycle evt_valid = 0, held = 0. No stale events after release of reset.
